// File: rtl/pll_lock_rst_pkg.sv
// Shared types and widths for the PLL-lock reset sequencer.
package pll_lock_rst_pkg;

    localparam int CNT_W      = 16;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/lock_sync.sv
// Parameterised single-bit synchronizer with asynchronous active-low clear.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Holds a clock domain in reset until PLL lock has been stable, then releases it.
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_rst_seq
    import pll_lock_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    logic             loss_event_s;
    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign loss_event_s = (state_r == ST_RUN) && !lock_s;

    // Qualification FSM; outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= {CNT_W{1'b0}};
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            case (state_r)
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_r <= ST_STABLE;
                    end else begin
                        state_r <= ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_STABLE;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                    end else if (cnt_r == HOLD_LAST) begin
                        state_r   <= ST_RUN;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        state_r <= ST_HOLD;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_r   <= ST_WAIT_LOCK;
                        lock_lost <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_r;

    // Saturating count of lock losses seen while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_r <= {LOSS_CNT_W{1'b0}};
        end else if (loss_event_s && (loss_cnt_r != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_cnt = loss_cnt_r;
`else
    assign lock_loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed self-checking bench for pll_lock_rst_seq (SYNC=2, STABLE=8, HOLD=4).
module tb_pll_lock_rst_seq;

`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int QUAL_EDGES = 15;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_loss = 0;

    pll_lock_rst_seq #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt();
        return CNT_EN ? exp_loss : 0;
    endfunction

    // Expect outputs low for n-1 edges and high exactly at edge n.
    task automatic expect_rise(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i < n) begin
                check_eq({tag, "_sys_low"}, sys_rst_n, 1'b0);
                check_eq({tag, "_rdy_low"}, ready, 1'b0);
            end else begin
                check_eq({tag, "_sys_high"}, sys_rst_n, 1'b1);
                check_eq({tag, "_rdy_high"}, ready, 1'b1);
            end
        end
    endtask

    // From RUN: drop lock, expect pulse on the third edge, then raise lock again.
    task automatic lose_lock(input string tag);
        pll_lock = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            check_eq({tag, "_ll_early"}, lock_lost, 1'b0);
            check_eq({tag, "_sys_still"}, sys_rst_n, 1'b1);
        end
        tick();
        if (exp_loss < 255) exp_loss++;
        check_eq({tag, "_ll_pulse"}, lock_lost, 1'b1);
        check_eq({tag, "_sys_fall"}, sys_rst_n, 1'b0);
        check_eq({tag, "_rdy_fall"}, ready, 1'b0);
        check_eq({tag, "_cnt"}, lock_loss_cnt, exp_cnt());
        tick();
        check_eq({tag, "_ll_end"}, lock_lost, 1'b0);
        check_eq({tag, "_sys_off"}, sys_rst_n, 1'b0);
        pll_lock = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        #2;
        check_eq("rst_sys", sys_rst_n, 1'b0);
        check_eq("rst_rdy", ready, 1'b0);
        check_eq("rst_ll", lock_lost, 1'b0);
        check_eq("rst_cnt", lock_loss_cnt, 8'd0);
        tick();
        tick();
        check_eq("rst_hold_sys", sys_rst_n, 1'b0);

        // Release with lock already high: full qualification.
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        expect_rise("qual", QUAL_EDGES);

        lose_lock("loss1");
        expect_rise("requal", QUAL_EDGES);

        // Glitch inside STABLE restarts qualification.
        lose_lock("loss2");
        for (int i = 0; i < 6; i++) tick();
        pll_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stab_dip_sys", sys_rst_n, 1'b0);
        end
        pll_lock = 1'b1;
        expect_rise("stab_restart", QUAL_EDGES);

        // Loss during HOLD: never reaches RUN, no pulse.
        lose_lock("loss3");
        for (int i = 0; i < 12; i++) tick();
        pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_sys", sys_rst_n, 1'b0);
            check_eq("hold_ll", lock_lost, 1'b0);
        end
        check_eq("hold_cnt", lock_loss_cnt, exp_cnt());
        pll_lock = 1'b1;
        expect_rise("hold_restart", QUAL_EDGES);

        // Asynchronous reset mid-RUN, between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sys", sys_rst_n, 1'b0);
        check_eq("arst_rdy", ready, 1'b0);
        check_eq("arst_ll", lock_lost, 1'b0);
        check_eq("arst_cnt", lock_loss_cnt, 8'd0);
        exp_loss = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("arst_ll_hold", lock_lost, 1'b0);
            check_eq("arst_sys_hold", sys_rst_n, 1'b0);
        end
        rst_n = 1'b1;
        expect_rise("arst_requal", QUAL_EDGES);

        // Counter saturation over 260 lock losses.
        for (int k = 0; k < 260; k++) begin
            lose_lock("sat");
            expect_rise("sat_requal", QUAL_EDGES);
        end
        check_eq("sat_final", lock_loss_cnt, CNT_EN ? 32'd255 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
